// File: rtl/fetch_seq_pkg.sv
// Shared types and constants for the dual-way fetch sequencer.
package fetch_seq_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } fetch_seq_state_e;

  localparam int INST_BYTES = 4;
  localparam int NUM_WAYS   = 2;

  // Number of set bits in a two-way flag vector (0..2).
  function automatic logic [1:0] count_ones2(input logic [1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]};
  endfunction

endpackage

// File: rtl/fetch_way_slot.sv
// Per-way tracking slot: remembers the PC of the single request in flight
// for this way and registers the delivered instruction towards the way buffer.
module fetch_way_slot
  import fetch_seq_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              issue,       // request for this way granted this cycle
  input  logic [ADDR_W-1:0] issue_addr,  // PC of that request
  input  logic              retire,      // response for this way arrives this cycle
  input  logic              deliver,     // response is kept (not discarded)
  input  logic [ADDR_W-1:0] rdata,
  output logic              inflight,
  output logic              valid,
  output logic [ADDR_W-1:0] inst,
  output logic [ADDR_W-1:0] addr
);

  logic [ADDR_W-1:0] slot_addr;

  // Track the outstanding request and register a one-cycle delivery strobe.
  // Issue and retire never coincide on one way: issue is gated by inflight.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      inflight  <= 1'b0;
      slot_addr <= '0;
      valid     <= 1'b0;
      inst      <= '0;
      addr      <= '0;
    end else begin
      valid <= retire & deliver;
      if (issue) begin
        inflight  <= 1'b1;
        slot_addr <= issue_addr;
      end else if (retire) begin
        inflight <= 1'b0;
      end
      if (retire & deliver) begin
        inst <= rdata;
        addr <= slot_addr;
      end
    end
  end

endmodule

// File: rtl/fetch_sequencer_dual.sv
// Fetch-side controller for the dual-way front end.
// Owns the fetch PC, issues requests on the instruction-memory port and
// steers in-order responses alternately into way0 / way1.
//
// Memory handshake: mem_req_o is a valid, mem_gnt_i is its ready; a request
// transfers on a cycle where both are high. While waiting for the grant the
// request and mem_addr_o hold steady; the only exception is jump_i, which
// withdraws the request in the same cycle. mem_rvalid_i has no back-pressure.
//
// Optional build macro FETCH_SEQ_PERF_EN adds three 32-bit performance
// counters (grants, discarded responses, RUN stall cycles).
module fetch_sequencer_dual
  import fetch_seq_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                jump_i,
  input  logic [ADDR_W-1:0]   jump_addr_i,
  output logic                mem_req_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [ADDR_W-1:0]   mem_rdata_i,
  input  logic [1:0]          way_ready_i,
  output logic [1:0]          way_valid_o,
  output logic [2*ADDR_W-1:0] way_inst_o,
  output logic [2*ADDR_W-1:0] way_addr_o,
  output logic                busy_o,
  output fetch_seq_state_e    state_o,
  output logic [1:0]          drop_cnt_o
`ifdef FETCH_SEQ_PERF_EN
  ,
  output logic [31:0]         perf_issued_o,
  output logic [31:0]         perf_dropped_o,
  output logic [31:0]         perf_stall_o
`endif
);

  fetch_seq_state_e  state;
  logic [ADDR_W-1:0] pc;
  logic              next_way;
  logic              resp_way;
  logic [1:0]        drop_cnt;
  logic [1:0]        inflight;
  logic              grant;
  logic              discard;
  logic [1:0]        live_cnt;
  logic [ADDR_W-1:0] jump_target;

  assign mem_req_o  = (state == RUN) & ~jump_i & way_ready_i[next_way] & ~inflight[next_way];
  assign mem_addr_o = pc;
  assign grant      = mem_req_o & mem_gnt_i;

  // A response is thrown away while draining, or when a redirect lands on it.
  assign discard    = jump_i | (drop_cnt != 2'd0);

  // Requests still outstanding once this cycle's response (if any) retires.
  // No grant can happen in a jump cycle, so new issues never add to this.
  assign live_cnt   = count_ones2(inflight) - {1'b0, mem_rvalid_i};

  assign jump_target = jump_addr_i & ~ADDR_W'(INST_BYTES - 1);

  assign busy_o     = (state == FLUSH);
  assign state_o    = state;
  assign drop_cnt_o = drop_cnt;

  // PC, redirect/flush state machine, drop counter and way steering pointers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc       <= RESET_PC;
      state    <= RUN;
      next_way <= 1'b0;
      resp_way <= 1'b0;
      drop_cnt <= 2'd0;
    end else begin
      if (grant) begin
        pc       <= pc + ADDR_W'(INST_BYTES);
        next_way <= ~next_way;
      end
      if (mem_rvalid_i) begin
        resp_way <= ~resp_way;
        if (drop_cnt != 2'd0) drop_cnt <= drop_cnt - 2'd1;
      end
      if (jump_i) begin
        pc <= jump_target;
        if (live_cnt == 2'd0) begin
          state    <= RUN;
          next_way <= 1'b0;
          resp_way <= 1'b0;
          drop_cnt <= 2'd0;
        end else begin
          state    <= FLUSH;
          drop_cnt <= live_cnt;
        end
      end else if ((state == FLUSH) && mem_rvalid_i && (drop_cnt == 2'd1)) begin
        // Last stale response gone: restart so the first new fetch hits way0.
        state    <= RUN;
        next_way <= 1'b0;
        resp_way <= 1'b0;
      end
    end
  end

  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
    fetch_way_slot #(
      .ADDR_W(ADDR_W)
    ) u_slot (
      .clk       (clk),
      .reset_n   (reset_n),
      .issue     (grant & (next_way == 1'(w))),
      .issue_addr(pc),
      .retire    (mem_rvalid_i & (resp_way == 1'(w))),
      .deliver   (~discard),
      .rdata     (mem_rdata_i),
      .inflight  (inflight[w]),
      .valid     (way_valid_o[w]),
      .inst      (way_inst_o[w*ADDR_W +: ADDR_W]),
      .addr      (way_addr_o[w*ADDR_W +: ADDR_W])
    );
  end

`ifdef FETCH_SEQ_PERF_EN
  // Free-running event counters; they wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      perf_issued_o  <= '0;
      perf_dropped_o <= '0;
      perf_stall_o   <= '0;
    end else begin
      if (grant)                  perf_issued_o  <= perf_issued_o + 32'd1;
      if (mem_rvalid_i & discard) perf_dropped_o <= perf_dropped_o + 32'd1;
      if ((state == RUN) & ~mem_req_o & ~jump_i)
                                  perf_stall_o   <= perf_stall_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer_dual.sv
// Directed bench for fetch_sequencer_dual with an in-order memory model and
// a delivery scoreboard.
`timescale 1ns/1ps
module tb_fetch_sequencer_dual;
  import fetch_seq_pkg::*;

  localparam int W = 32;

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             jump_i = 1'b0;
  logic [W-1:0]     jump_addr_i = '0;
  logic             mem_req_o;
  logic [W-1:0]     mem_addr_o;
  logic             mem_gnt_i = 1'b0;
  logic             mem_rvalid_i = 1'b0;
  logic [W-1:0]     mem_rdata_i = '0;
  logic [1:0]       way_ready_i = 2'b00;
  logic [1:0]       way_valid_o;
  logic [2*W-1:0]   way_inst_o;
  logic [2*W-1:0]   way_addr_o;
  logic             busy_o;
  fetch_seq_state_e state_o;
  logic [1:0]       drop_cnt_o;
`ifdef FETCH_SEQ_PERF_EN
  logic [31:0]      perf_issued_o, perf_dropped_o, perf_stall_o;
`endif

  always #5 clk = ~clk;

  fetch_sequencer_dual #(
    .ADDR_W  (W),
    .RESET_PC(32'h8000_0000)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .jump_i      (jump_i),
    .jump_addr_i (jump_addr_i),
    .mem_req_o   (mem_req_o),
    .mem_addr_o  (mem_addr_o),
    .mem_gnt_i   (mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i (mem_rdata_i),
    .way_ready_i (way_ready_i),
    .way_valid_o (way_valid_o),
    .way_inst_o  (way_inst_o),
    .way_addr_o  (way_addr_o),
    .busy_o      (busy_o),
    .state_o     (state_o),
    .drop_cnt_o  (drop_cnt_o)
`ifdef FETCH_SEQ_PERF_EN
    ,
    .perf_issued_o (perf_issued_o),
    .perf_dropped_o(perf_dropped_o),
    .perf_stall_o  (perf_stall_o)
`endif
  );

  // ---------------- check bookkeeping ----------------
  int n_total = 0;
  int n_pass  = 0;
  logic [32:0] exp_q[$];  // {way, pc} of each expected delivery, in order

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [W-1:0] data_of(input logic [W-1:0] a);
    return a ^ 32'h5A5A_F00F;
  endfunction

  // ---------------- memory model ----------------
  logic [W-1:0] pend_addr[$];
  int           pend_due[$];
  int           cyc = 0;
  int           mem_lat = 2;

  // Record each grant with the edge at which its in-order response is due.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!reset_n) begin
      pend_addr.delete();
      pend_due.delete();
    end else if (mem_req_o && mem_gnt_i) begin
      int due;
      due = cyc + mem_lat;
      if (pend_due.size() != 0 && due <= pend_due[$]) due = pend_due[$] + 1;
      pend_addr.push_back(mem_addr_o);
      pend_due.push_back(due);
    end
  end

  // Present the response half a cycle before the edge it is due on.
  always @(negedge clk) begin
    mem_rvalid_i = 1'b0;
    if (reset_n && pend_due.size() != 0 && pend_due[0] == cyc + 1) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = data_of(pend_addr[0]);
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
  end

  // ---------------- monitor ----------------
  logic [1:0] prev_valid = 2'b00;

  // Compare every way delivery against the head of the expected queue.
  always @(negedge clk) begin
    logic [32:0] e;
    if (reset_n) begin
      for (int w = 0; w < 2; w++) begin
        if (way_valid_o[w]) begin
          check("valid_pulse", {31'b0, prev_valid[w]}, 32'd0);
          if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_delivery: way %0d pc %h, expected none (t=%0t)",
                     w, way_addr_o[w*W +: W], $time);
          end else begin
            e = exp_q.pop_front();
            check("deliver_way", 32'(w), {31'b0, e[32]});
            check("deliver_addr", way_addr_o[w*W +: W], e[W-1:0]);
            check("deliver_inst", way_inst_o[w*W +: W], data_of(e[W-1:0]));
          end
        end
      end
    end
    prev_valid = reset_n ? way_valid_o : 2'b00;
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    reset_n     = 1'b0;
    jump_i      = 1'b0;
    jump_addr_i = '0;
    mem_gnt_i   = 1'b0;
    way_ready_i = 2'b00;
    repeat (2) @(negedge clk);
    exp_q.delete();
    check("rst_valid", {30'b0, way_valid_o}, 32'd0);
    check("rst_inst0", way_inst_o[W-1:0], 32'd0);
    check("rst_inst1", way_inst_o[2*W-1:W], 32'd0);
    check("rst_addr0", way_addr_o[W-1:0], 32'd0);
    check("rst_addr1", way_addr_o[2*W-1:W], 32'd0);
    check("rst_busy", {31'b0, busy_o}, 32'd0);
    check("rst_state", {31'b0, state_o}, {31'b0, RUN});
    check("rst_drop", {30'b0, drop_cnt_o}, 32'd0);
    check("rst_req", {31'b0, mem_req_o}, 32'd0);
    check("rst_pc", mem_addr_o, 32'h8000_0000);
    reset_n = 1'b1;
  endtask

  // Grant n requests, checking each address; push expected deliveries.
  task automatic run_grants(input int n, input logic [W-1:0] first_addr,
                            input logic first_way, input logic deliver);
    logic [W-1:0] a;
    logic         way;
    int           got;
    int           cycles;
    a = first_addr; way = first_way; got = 0; cycles = 0;
    mem_gnt_i = 1'b1;
    while (got < n) begin
      if (cycles == 30) begin
        n_total++;
        $display("FAIL grant_timeout: got %0d grants, expected %0d", got, n);
        break;
      end
      #1;
      if (mem_req_o) begin
        check("issue_addr", mem_addr_o, a);
        if (deliver) exp_q.push_back({way, a});
        a = a + 32'd4;
        way = ~way;
        got++;
      end
      @(negedge clk);
      cycles++;
    end
    mem_gnt_i = 1'b0;
  endtask

  task automatic drain();
    int cycles;
    cycles = 0;
    while ((exp_q.size() != 0 || pend_due.size() != 0) && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_not_busy();
    int c;
    c = 0;
    while (busy_o && c < 20) begin
      @(negedge clk);
      c++;
    end
    check("flush_exit_busy", {31'b0, busy_o}, 32'd0);
  endtask

  // ---------------- directed sequences ----------------
  initial begin
    logic found;

    // Streaming: alternate ways, in-order addresses, single-cycle strobes.
    mem_lat = 2;
    do_reset();
    way_ready_i = 2'b11;
    run_grants(4, 32'h8000_0000, 1'b0, 1'b1);
    drain();

    // One request per way: both in flight blocks further issue.
    do_reset();
    way_ready_i = 2'b11;
    mem_lat = 6;
    run_grants(2, 32'h8000_0000, 1'b0, 1'b1);
    repeat (3) begin
      #1; check("inflight_block", {31'b0, mem_req_o}, 32'd0);
      @(negedge clk);
    end
    run_grants(2, 32'h8000_0008, 1'b0, 1'b1);
    drain();

    // way1 buffer not ready: issue stalls on next_way=1 until it is.
    do_reset();
    way_ready_i = 2'b01;
    mem_lat = 2;
    run_grants(1, 32'h8000_0000, 1'b0, 1'b1);
    repeat (5) begin
      #1; check("ready_block", {31'b0, mem_req_o}, 32'd0);
      @(negedge clk);
    end
    way_ready_i = 2'b11;
    run_grants(1, 32'h8000_0004, 1'b1, 1'b1);
    drain();

    // Jump with two requests in flight: both dropped, restart in way0.
    do_reset();
    way_ready_i = 2'b11;
    mem_lat = 4;
    run_grants(2, 32'h8000_0000, 1'b0, 1'b0);
    jump_i = 1'b1;
    jump_addr_i = 32'h0000_1003;
    @(negedge clk);
    jump_i = 1'b0;
    #1;
    check("flush_busy", {31'b0, busy_o}, 32'd1);
    check("flush_state", {31'b0, state_o}, {31'b0, FLUSH});
    check("flush_drop_cnt", {30'b0, drop_cnt_o}, 32'd2);
    check("flush_no_req", {31'b0, mem_req_o}, 32'd0);
    @(negedge clk);
    wait_not_busy();
    mem_lat = 2;
    run_grants(1, 32'h0000_1000, 1'b0, 1'b1);
    drain();

    // Jump coinciding with the only outstanding response.
    do_reset();
    way_ready_i = 2'b11;
    mem_lat = 3;
    run_grants(1, 32'h8000_0000, 1'b0, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      #1;
      if (mem_rvalid_i) found = 1'b1;
      else @(negedge clk);
    end
    check("rvalid_seen", {31'b0, found}, 32'd1);
    jump_i = 1'b1;
    jump_addr_i = 32'h0000_2000;
    @(negedge clk);
    jump_i = 1'b0;
    #1;
    check("lastdrop_state", {31'b0, state_o}, {31'b0, RUN});
    check("lastdrop_busy", {31'b0, busy_o}, 32'd0);
    check("lastdrop_drop_cnt", {30'b0, drop_cnt_o}, 32'd0);
    check("lastdrop_addr", mem_addr_o, 32'h0000_2000);
    check("lastdrop_req", {31'b0, mem_req_o}, 32'd1);
    @(negedge clk);
    mem_lat = 2;
    run_grants(2, 32'h0000_2000, 1'b0, 1'b1);
    drain();

    // Grant withheld: request holds; jump withdraws it the same cycle.
    do_reset();
    way_ready_i = 2'b11;
    repeat (5) begin
      #1;
      check("hold_req", {31'b0, mem_req_o}, 32'd1);
      check("hold_addr", mem_addr_o, 32'h8000_0000);
      @(negedge clk);
    end
    jump_i = 1'b1;
    jump_addr_i = 32'h0000_3000;
    #1;
    check("jump_withdraw", {31'b0, mem_req_o}, 32'd0);
    @(negedge clk);
    jump_i = 1'b0;
    #1;
    check("jump_target", mem_addr_o, 32'h0000_3000);
    check("jump_req", {31'b0, mem_req_o}, 32'd1);
    @(negedge clk);

    // PC wrap from FFFF_FFFC to 0000_0000.
    do_reset();
    way_ready_i = 2'b11;
    mem_lat = 2;
    jump_i = 1'b1;
    jump_addr_i = 32'hFFFF_FFFE;
    @(negedge clk);
    jump_i = 1'b0;
    run_grants(2, 32'hFFFF_FFFC, 1'b0, 1'b1);
    drain();
    #1;
    check("wrap_pc", mem_addr_o, 32'h0000_0004);
`ifdef FETCH_SEQ_PERF_EN
    check("perf_issued", perf_issued_o, 32'd2);
    check("perf_dropped", perf_dropped_o, 32'd0);
`endif
    @(negedge clk);

    // Reset in the middle of a flush clears all tracking.
    do_reset();
    way_ready_i = 2'b11;
    mem_lat = 4;
    run_grants(2, 32'h8000_0000, 1'b0, 1'b0);
    jump_i = 1'b1;
    jump_addr_i = 32'h0000_5000;
    @(negedge clk);
    jump_i = 1'b0;
    #1;
    check("midflush_busy", {31'b0, busy_o}, 32'd1);
    do_reset();
    way_ready_i = 2'b11;
    mem_lat = 2;
    run_grants(2, 32'h8000_0000, 1'b0, 1'b1);
    drain();

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Hard stop if a sequence ever stalls beyond any reasonable length.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d of %0d passed", n_pass, n_total);
    $fatal(1);
  end

endmodule
